// File: rtl/gps_bpsk_tx_if.sv
// Handshake and signal bundle for gps_bpsk_tx.
// master: the side that feeds taps, control and data bits and watches the outputs.
// slave:  the transmitter itself.
interface gps_bpsk_tx_if #(
    parameter int NCO_W = 16
);
    logic             start;
    logic             stop;
    logic [3:0]       prn_tap1;
    logic [3:0]       prn_tap2;
    logic [NCO_W-1:0] fcw;
    logic             bit_in;
    logic             bit_valid;
    logic             bit_ready;
    logic             tx_out;
    logic             prn_out;
    logic             sin_out;
    logic             cos_out;
    logic             code_epoch;
    logic             bit_epoch;
    logic             busy;
    logic             underrun;

    modport master (
        output start, stop, prn_tap1, prn_tap2, fcw, bit_in, bit_valid,
        input  bit_ready, tx_out, prn_out, sin_out, cos_out,
               code_epoch, bit_epoch, busy, underrun
    );

    modport slave (
        input  start, stop, prn_tap1, prn_tap2, fcw, bit_in, bit_valid,
        output bit_ready, tx_out, prn_out, sin_out, cos_out,
               code_epoch, bit_epoch, busy, underrun
    );
endinterface

// File: rtl/gps_bpsk_tx.sv
// GPS L1 C/A BPSK transmitter: Gold-code generator (G1/G2 LFSRs with
// phase-select taps), navigation bit sequencing with a one-entry holding
// register, and an optional 1-bit carrier NCO.
// Optional feature macro: GPS_TX_CARRIER_EN (carrier NCO and carrier mixing).
module gps_bpsk_tx #(
    parameter int CHIP_DIV      = 4,
    parameter int CODES_PER_BIT = 20,
    parameter int NCO_W         = 16
) (
    input logic          CLK,
    input logic          RST,
    gps_bpsk_tx_if.slave bus
);
    localparam int              DIV_W     = (CHIP_DIV > 1) ? $clog2(CHIP_DIV) : 1;
    localparam int              CC_W      = (CODES_PER_BIT > 1) ? $clog2(CODES_PER_BIT) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CHIP_DIV - 1);
    localparam logic [CC_W-1:0]  CC_LAST   = CC_W'(CODES_PER_BIT - 1);
    localparam logic [9:0]       CHIP_LAST = 10'd1022;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRIME = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic [3:0]       r_tap1;
    logic [3:0]       r_tap2;
    logic [10:1]      r_g1;
    logic [10:1]      r_g2;
    logic [DIV_W-1:0] r_div;
    logic [9:0]       r_chip_cnt;
    logic [CC_W-1:0]  r_code_cnt;
    logic             r_cur_bit;
    logic             r_hold_bit;
    logic             r_hold_full;
    logic             r_stop;
    logic             r_underrun;

    logic             w_taps_ok;
    logic             w_start_ok;
    logic             w_run;
    logic             w_hs;
    logic             w_tick;
    logic             w_code_wrap;
    logic             w_bit_bound;
    logic             w_stop_pend;
    logic             w_g1_fb;
    logic             w_g2_fb;
    logic             w_prn;
    logic             w_sin;
    logic             w_cos;

    logic             w_bit_ready;
    logic             w_tx;
    logic             w_prn_o;
    logic             w_sin_o;
    logic             w_cos_o;
    logic             w_code_epoch;
    logic             w_bit_epoch;
    logic             w_busy;

    // Select one G2 stage by a 1..10 tap number; anything else reads as 0.
    function automatic logic g2_sel(input logic [10:1] g, input logic [3:0] tap);
        logic v;
        v = 1'b0;
        case (tap)
            4'd1:    v = g[1];
            4'd2:    v = g[2];
            4'd3:    v = g[3];
            4'd4:    v = g[4];
            4'd5:    v = g[5];
            4'd6:    v = g[6];
            4'd7:    v = g[7];
            4'd8:    v = g[8];
            4'd9:    v = g[9];
            4'd10:   v = g[10];
            default: v = 1'b0;
        endcase
        return v;
    endfunction

    assign w_taps_ok   = (bus.prn_tap1 >= 4'd1) && (bus.prn_tap1 <= 4'd10) &&
                         (bus.prn_tap2 >= 4'd1) && (bus.prn_tap2 <= 4'd10);
    assign w_start_ok  = (r_state == S_IDLE) && bus.start && w_taps_ok;
    assign w_run       = (r_state == S_RUN);
    assign w_hs        = bus.bit_valid && w_bit_ready;
    assign w_tick      = w_run && (r_div == DIV_LAST);
    assign w_code_wrap = w_tick && (r_chip_cnt == CHIP_LAST);
    assign w_bit_bound = w_code_wrap && (r_code_cnt == CC_LAST);
    // A stop arriving on the boundary cycle itself still ends the run there.
    assign w_stop_pend = r_stop || bus.stop;

    assign w_g1_fb = r_g1[3] ^ r_g1[10];
    assign w_g2_fb = r_g2[2] ^ r_g2[3] ^ r_g2[6] ^ r_g2[8] ^ r_g2[9] ^ r_g2[10];
    assign w_prn   = r_g1[10] ^ g2_sel(r_g2, r_tap1) ^ g2_sel(r_g2, r_tap2);

`ifdef GPS_TX_CARRIER_EN
    logic [NCO_W-1:0] r_acc;

    // Carrier phase accumulator: cleared on start, free-running only in RUN.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_acc <= '0;
        end else if (w_start_ok) begin
            r_acc <= '0;
        end else if (w_run) begin
            r_acc <= r_acc + bus.fcw;
        end
    end

    assign w_sin = r_acc[NCO_W-1];
    assign w_cos = r_acc[NCO_W-1] ^ r_acc[NCO_W-2];
`else
    logic [NCO_W-1:0] w_unused_fcw;

    assign w_unused_fcw = bus.fcw;
    assign w_sin        = 1'b0;
    assign w_cos        = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state: stop in PRIME wins over a same-cycle handshake.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_next_state = S_PRIME;
                end
            end
            S_PRIME: begin
                if (bus.stop) begin
                    w_next_state = S_IDLE;
                end else if (w_hs) begin
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                if (w_bit_bound && w_stop_pend) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // FSM outputs: every modulated output is gated to 0 outside RUN.
    always_comb begin
        w_busy       = (r_state != S_IDLE);
        w_bit_ready  = 1'b0;
        w_tx         = 1'b0;
        w_prn_o      = 1'b0;
        w_sin_o      = 1'b0;
        w_cos_o      = 1'b0;
        w_code_epoch = 1'b0;
        w_bit_epoch  = 1'b0;
        case (r_state)
            S_PRIME: begin
                w_bit_ready = 1'b1;
            end
            S_RUN: begin
                w_bit_ready  = (r_code_cnt == CC_LAST) && !r_hold_full;
                w_prn_o      = w_prn;
                w_sin_o      = w_sin;
                w_cos_o      = w_cos;
                w_tx         = r_cur_bit ^ w_prn ^ w_sin;
                w_code_epoch = (r_chip_cnt == 10'd0) && (r_div == '0);
                w_bit_epoch  = (r_chip_cnt == 10'd0) && (r_div == '0) && (r_code_cnt == '0);
            end
            default: begin
                w_bit_ready = 1'b0;
            end
        endcase
    end

    assign bus.bit_ready  = w_bit_ready;
    assign bus.tx_out     = w_tx;
    assign bus.prn_out    = w_prn_o;
    assign bus.sin_out    = w_sin_o;
    assign bus.cos_out    = w_cos_o;
    assign bus.code_epoch = w_code_epoch;
    assign bus.bit_epoch  = w_bit_epoch;
    assign bus.busy       = w_busy;
    assign bus.underrun   = r_underrun;

    // Code generator, counters and data-bit sequencing.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_tap1      <= '0;
            r_tap2      <= '0;
            r_g1        <= '0;
            r_g2        <= '0;
            r_div       <= '0;
            r_chip_cnt  <= '0;
            r_code_cnt  <= '0;
            r_cur_bit   <= 1'b0;
            r_hold_bit  <= 1'b0;
            r_hold_full <= 1'b0;
            r_stop      <= 1'b0;
            r_underrun  <= 1'b0;
        end else if (w_start_ok) begin
            r_tap1      <= bus.prn_tap1;
            r_tap2      <= bus.prn_tap2;
            r_g1        <= '1;
            r_g2        <= '1;
            r_div       <= '0;
            r_chip_cnt  <= '0;
            r_code_cnt  <= '0;
            r_cur_bit   <= 1'b0;
            r_hold_full <= 1'b0;
            r_stop      <= 1'b0;
            r_underrun  <= 1'b0;
        end else if (r_state == S_PRIME) begin
            if (w_hs && !bus.stop) begin
                r_cur_bit <= bus.bit_in;
            end
        end else if (w_run) begin
            if (bus.stop) begin
                r_stop <= 1'b1;
            end
            r_div <= w_tick ? '0 : r_div + 1'b1;
            if (w_code_wrap) begin
                r_chip_cnt <= '0;
                r_g1       <= '1;
                r_g2       <= '1;
                r_code_cnt <= (r_code_cnt == CC_LAST) ? '0 : r_code_cnt + 1'b1;
            end else if (w_tick) begin
                r_chip_cnt <= r_chip_cnt + 10'd1;
                r_g1       <= {r_g1[9:1], w_g1_fb};
                r_g2       <= {r_g2[9:1], w_g2_fb};
            end
            // A bit offered on the boundary cycle with an empty holding
            // register goes straight into the current bit.
            if (w_bit_bound) begin
                if (r_hold_full) begin
                    r_cur_bit   <= r_hold_bit;
                    r_hold_full <= 1'b0;
                end else if (w_hs) begin
                    r_cur_bit <= bus.bit_in;
                end else begin
                    r_underrun <= 1'b1;
                end
            end else if (w_hs) begin
                r_hold_bit  <= bus.bit_in;
                r_hold_full <= 1'b1;
            end
        end
    end
endmodule

// File: doc/gps_bpsk_tx.md
GPS_BPSK_TX -- requirements
Module: gps_bpsk_tx

Interface
REQ-001 SHALL have parameter CHIP_DIV, default 4: clock cycles per chip; legal range ≥1.
REQ-002 SHALL have parameter CODES_PER_BIT, default 20: C/A code periods per data bit; legal range ≥1.
REQ-003 SHALL have parameter NCO_W, default 16: carrier phase accumulator width; legal range ≥2.
REQ-004 SHALL have the following ports, clock and reset first:
- CLK  in  1: single clock.
- RST  in  1: asynchronous, active-low reset.
- start  in  1: begin transmission.
- stop  in  1: end transmission at the next bit boundary.
- prn_tap1, prn_tap2  in  4 each: G2 phase-select taps, legal values 1..10.
- fcw  in  NCO_W: carrier frequency control word.
- bit_in  in  1: next navigation data bit.
- bit_valid  in  1: bit_in is valid.
- bit_ready  out  1: the block can accept bit_in.
- tx_out  out  1: modulated sample.
- prn_out  out  1: current chip.
- sin_out, cos_out  out  1 each: 1-bit carrier.
- code_epoch, bit_epoch  out  1 each: single-cycle pulses.
- busy  out  1: state is not IDLE.
- underrun  out  1: sticky data-starvation flag.

Function
REQ-005 SHALL implement FSM states IDLE, PRIME and RUN.
REQ-006 IDLE: on start with both taps in 1..10 -> PRIME. With any tap at 0 or >10, start SHALL be ignored.
REQ-007 On the IDLE->PRIME transition, SHALL:
- latch both taps;
- set G1 and G2 to all ones;
- clear the chip, code and divider counters, the accumulator and underrun.
REQ-008 PRIME: bit_ready=1. On bit_valid&bit_ready, SHALL load the current bit and enter RUN on the next cycle.
REQ-009 RUN: chip tick SHALL occur when the divider reaches CHIP_DIV-1; the divider then wraps to 0.
REQ-010 G1 feedback SHALL be taps 3^10; G2 feedback SHALL be taps 2^3^6^8^9^10.
REQ-011 prn_out SHALL equal G1[10]^G2[tap1]^G2[tap2].
REQ-012 On each chip tick, both LFSRs SHALL shift and chip_cnt SHALL increment.
REQ-013 At chip_cnt=1022, the tick SHALL wrap chip_cnt to 0, reload both LFSRs to all ones and increment code_cnt modulo CODES_PER_BIT.
REQ-014 bit_ready SHALL be 1 in RUN while code_cnt=CODES_PER_BIT-1 and the one-entry holding register is empty.
REQ-015 A handshake in RUN SHALL fill the holding register.
REQ-016 Bit boundary (the tick wrapping code_cnt to 0): the current bit SHALL take the held bit and the register SHALL be emptied. If the register is empty, the current bit SHALL repeat and underrun SHALL be set.
REQ-017 code_epoch SHALL pulse on the first cycle of chip 0 of every code period, including the first RUN cycle.
REQ-018 bit_epoch SHALL pulse when code_epoch pulses with code_cnt=0.
REQ-019 stop SHALL be latched in RUN. The block SHALL go to IDLE at the next bit boundary; stop in PRIME SHALL go to IDLE immediately.
REQ-020 start in PRIME or RUN SHALL be ignored.
REQ-021 In RUN, the accumulator SHALL add fcw every cycle, modulo 2^NCO_W.
REQ-022 sin_out SHALL be acc[MSB]; cos_out SHALL be acc[MSB]^acc[MSB-1].
REQ-023 tx_out SHALL be current_bit^prn_out^sin_out, formed only from registered state with no extra latency.
REQ-024 In IDLE and PRIME, tx_out, prn_out, sin_out, cos_out and both epochs SHALL be 0.

Reset
REQ-025 On RST low, the block SHALL asynchronously enter IDLE, zero all registers and drive every output 0.
REQ-026 Reset asserted mid-RUN SHALL abandon the current bit with no further handshake.

Configuration
REQ-027 With GPS_TX_CARRIER_EN defined, SHALL implement the NCO and REQ-023 as specified.
REQ-028 Without GPS_TX_CARRIER_EN, SHALL omit the accumulator, tie sin_out=cos_out=0 and set tx_out=current_bit^prn_out.

Verification
REQ-029 Bench SHALL cover: RST low during RUN -> busy=0, bit_ready=0, underrun=0 and all outputs 0 within the same cycle.
REQ-030 Bench SHALL cover: CHIP_DIV=1, taps 2,6 -> first 10 prn_out chips 1100100000, code_epoch every 1023 cycles; taps 3,7 -> first chips 1110010000.
REQ-031 Bench SHALL cover: macro off, CODES_PER_BIT=2, bits 1,0 -> tx_out=~prn_out for 2046 cycles, then tx_out=prn_out, with bit_epoch at cycles 0 and 2046.
REQ-032 Bench SHALL cover: no bit offered in the last period -> current bit repeats, underrun=1 held until the next start.
REQ-033 Bench SHALL cover: macro on, fcw=2^(NCO_W-2) -> sin_out 0,0,1,1 and cos_out 0,1,1,0 repeating.
REQ-034 Bench SHALL cover: stop mid-bit -> busy=1 until the bit boundary, then IDLE; start with tap1=0 -> remains IDLE.
